// File: rtl/register_file_pkg.sv
// Shared encodings for the per-thread register file: core phases, write-source
// select codes and the indices of the read-only special registers.
package register_file_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [1:0] {
        WR_ALU      = 2'b00,
        WR_LSU      = 2'b01,
        WR_IMM      = 2'b10,
        WR_RESERVED = 2'b11
    } wr_src_e;

    localparam int NUM_REGS = 16;
    localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
    localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] REG_THREAD_IDX = 4'd15;

    // R13..R15 are special and never accept instruction writes.
    function automatic logic is_read_only(input logic [3:0] addr);
        return (addr == REG_BLOCK_IDX) || (addr == REG_BLOCK_DIM) || (addr == REG_THREAD_IDX);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/operand bundle between the thread core (master) and its register file (slave).
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic [7:0]           block_id;
    core_state_e          core_state;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    wr_src_e              decoded_reg_input_mux;
    logic [7:0]           decoded_immediate;
    logic [7:0]           alu_out;
    logic [7:0]           lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;
    logic                 ro_write_err;
    logic [3:0]           dbg_addr;
    logic [DATA_BITS-1:0] dbg_data;

    modport master (
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output alu_out, lsu_out, dbg_addr,
        input  rs, rt, ro_write_err, dbg_data
    );

    modport slave (
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  alu_out, lsu_out, dbg_addr,
        output rs, rt, ro_write_err, dbg_data
    );

endinterface

// File: rtl/register_file.sv
// Per-thread register file: 13 general registers plus read-only %blockIdx,
// %blockDim and %threadIdx, with registered operand reads and a debug port.
module register_file
    import register_file_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);

    logic [DATA_BITS-1:0] regs_reg [NUM_REGS];
    logic [DATA_BITS-1:0] rs_reg;
    logic [DATA_BITS-1:0] rt_reg;
    logic                 ro_write_err_reg;

    logic [DATA_BITS-1:0] wr_data_next;
    logic                 wr_request;
    logic                 wr_legal;
    logic                 rd_request;

    always_comb begin
        wr_data_next = '0;
        unique case (bus.decoded_reg_input_mux)
            WR_ALU:      wr_data_next = DATA_BITS'(bus.alu_out);
            WR_LSU:      wr_data_next = DATA_BITS'(bus.lsu_out);
            WR_IMM:      wr_data_next = DATA_BITS'(bus.decoded_immediate);
            WR_RESERVED: wr_data_next = '0;
        endcase
    end

    assign rd_request = bus.enable && (bus.core_state == ST_REQUEST);
    assign wr_request = bus.enable && (bus.core_state == ST_UPDATE) && bus.decoded_reg_write_enable;
    assign wr_legal   = !is_read_only(bus.decoded_rd_address) &&
                        (bus.decoded_reg_input_mux != WR_RESERVED);

    // REQUEST and UPDATE never coincide, so operand reads see pre-edge contents
    // without any bypass from the write path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            regs_reg[REG_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
            regs_reg[REG_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
            rs_reg           <= '0;
            rt_reg           <= '0;
            ro_write_err_reg <= 1'b0;
        end else if (bus.enable) begin
            if (rd_request) begin
                rs_reg <= regs_reg[bus.decoded_rs_address];
                rt_reg <= regs_reg[bus.decoded_rt_address];
            end
            if (wr_request) begin
                if (wr_legal) begin
                    regs_reg[bus.decoded_rd_address] <= wr_data_next;
                end else begin
                    ro_write_err_reg <= 1'b1;
                end
            end
            regs_reg[REG_BLOCK_IDX] <= DATA_BITS'(bus.block_id);
        end
    end

    assign bus.rs           = rs_reg;
    assign bus.rt           = rt_reg;
    assign bus.ro_write_err = ro_write_err_reg;
    assign bus.dbg_data     = regs_reg[bus.dbg_addr];

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized checks of register_file against an array-based model.
`timescale 1ns/1ps
module tb_register_file;
    import register_file_pkg::*;

    localparam int TPB = 4;
    localparam int TID = 2;

    logic clk;
    logic reset;

    register_file_if #(.DATA_BITS(8)) bus ();

    register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Behavioural model: architectural state only.
    int m_regs [16];
    int m_rs;
    int m_rt;
    int m_err;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_regs[14] = TPB;
        m_regs[15] = TID;
        m_rs = 0;
        m_rt = 0;
        m_err = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dbg(input string tag, input int addr, input int exp);
        bus.dbg_addr = 4'(addr);
        #1;
        check(tag, int'(bus.dbg_data), exp);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.dbg_addr = 4'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), int'(bus.dbg_data), m_regs[i]);
        end
    endtask

    // One clock cycle with the given inputs; the model advances from the same inputs.
    task automatic step(input bit en, input core_state_e st, input int rs_a, input int rt_a,
                        input int rd_a, input bit we, input wr_src_e mux, input int imm,
                        input int alu, input int lsu, input int blk);
        int src;
        bus.enable                   = en;
        bus.core_state               = st;
        bus.decoded_rs_address       = 4'(rs_a);
        bus.decoded_rt_address       = 4'(rt_a);
        bus.decoded_rd_address       = 4'(rd_a);
        bus.decoded_reg_write_enable = we;
        bus.decoded_reg_input_mux    = mux;
        bus.decoded_immediate        = 8'(imm);
        bus.alu_out                  = 8'(alu);
        bus.lsu_out                  = 8'(lsu);
        bus.block_id                 = 8'(blk);
        @(posedge clk);
        #1;
        if (en) begin
            if (st == ST_REQUEST) begin
                m_rs = m_regs[rs_a];
                m_rt = m_regs[rt_a];
            end
            if (st == ST_UPDATE && we) begin
                src = (mux == WR_ALU) ? alu : (mux == WR_LSU) ? lsu : imm;
                if (rd_a >= 13 || mux == WR_RESERVED) m_err = 1;
                else m_regs[rd_a] = src & 8'hFF;
            end
            m_regs[13] = blk & 8'hFF;
        end
        $display("t=%0t en=%0b st=%0d rs_a=%0d rt_a=%0d rd_a=%0d we=%0b mux=%0d imm=%02h alu=%02h lsu=%02h blk=%02h -> rs=%02h rt=%02h err=%0b",
                 $time, en, st, rs_a, rt_a, rd_a, we, mux, imm & 8'hFF, alu & 8'hFF, lsu & 8'hFF,
                 blk & 8'hFF, bus.rs, bus.rt, bus.ro_write_err);
        check("rs", int'(bus.rs), m_rs);
        check("rt", int'(bus.rt), m_rt);
        check("ro_write_err", int'(bus.ro_write_err), m_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        bus.core_state = ST_IDLE;
        bus.decoded_rs_address = '0;
        bus.decoded_rt_address = '0;
        bus.decoded_rd_address = '0;
        bus.decoded_reg_write_enable = 1'b0;
        bus.decoded_reg_input_mux = WR_ALU;
        bus.decoded_immediate = '0;
        bus.alu_out = '0;
        bus.lsu_out = '0;
        bus.block_id = '0;
        bus.dbg_addr = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values.
        check_dbg("reset_r14", 14, TPB);
        check_dbg("reset_r15", 15, TID);
        check_dbg("reset_r0", 0, 0);
        check("reset_err", int'(bus.ro_write_err), 0);
        check("reset_rs", int'(bus.rs), 0);
        check_all_regs("reset");

        // Immediate write then operand read, including a special register.
        step(1, ST_UPDATE, 0, 0, 3, 1, WR_IMM, 8'h5A, 0, 0, 0);
        step(1, ST_REQUEST, 3, 15, 0, 0, WR_ALU, 0, 0, 0, 0);
        check("imm_rs", int'(bus.rs), 8'h5A);
        check("imm_rt", int'(bus.rt), TID);

        // Consecutive writes to the same register: last one wins.
        step(1, ST_UPDATE, 0, 0, 1, 1, WR_ALU, 0, 8'h7F, 0, 0);
        step(1, ST_UPDATE, 0, 0, 1, 1, WR_LSU, 0, 0, 8'h80, 0);
        check_dbg("last_write_r1", 1, 8'h80);

        // Write to a read-only register is dropped and the flag sticks.
        step(1, ST_UPDATE, 0, 0, 14, 1, WR_IMM, 8'h33, 0, 0, 0);
        check_dbg("ro_r14", 14, TPB);
        check("ro_err_set", int'(bus.ro_write_err), 1);
        step(1, ST_UPDATE, 0, 0, 2, 1, WR_IMM, 8'h44, 0, 0, 0);
        check("ro_err_sticky", int'(bus.ro_write_err), 1);
        check_dbg("legal_r2", 2, 8'h44);

        // Disabled thread ignores REQUEST/UPDATE and does not mirror block_id.
        step(0, ST_REQUEST, 1, 2, 0, 0, WR_ALU, 0, 0, 0, 9);
        step(0, ST_UPDATE, 0, 0, 4, 1, WR_IMM, 8'hAB, 0, 0, 9);
        check("dis_rs", int'(bus.rs), 8'h5A);
        check_dbg("dis_r13", 13, 0);
        check_dbg("dis_r4", 4, 0);
        check_all_regs("dis");
        step(1, ST_IDLE, 0, 0, 0, 0, WR_ALU, 0, 0, 0, 9);
        check_dbg("en_r13", 13, 9);

        // Reserved mux code drops the write (clear the flag via reset first).
        reset = 1'b1;
        #1;
        model_reset();
        reset = 1'b0;
        check("rst_clears_err", int'(bus.ro_write_err), 0);
        step(1, ST_UPDATE, 0, 0, 6, 1, WR_RESERVED, 8'h12, 8'h34, 8'h56, 0);
        check_dbg("rsv_r6", 6, 0);
        check("rsv_err", int'(bus.ro_write_err), 1);

        // Reset asserted in the middle of an UPDATE cycle aborts the write.
        step(1, ST_UPDATE, 0, 0, 5, 1, WR_IMM, 8'h11, 0, 0, 0);
        step(1, ST_REQUEST, 5, 5, 0, 0, WR_ALU, 0, 0, 0, 0);
        bus.core_state = ST_UPDATE;
        bus.decoded_rd_address = 4'd5;
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_reg_input_mux = WR_IMM;
        bus.decoded_immediate = 8'hFF;
        #10;
        reset = 1'b1;
        #1;
        model_reset();
        check_dbg("midrst_r5", 5, 0);
        check("midrst_rs", int'(bus.rs), 0);
        check("midrst_rt", int'(bus.rt), 0);
        check_dbg("midrst_r14", 14, TPB);
        @(posedge clk);
        #1;
        bus.core_state = ST_IDLE;
        bus.decoded_reg_write_enable = 1'b0;
        reset = 1'b0;
        step(1, ST_IDLE, 0, 0, 0, 0, WR_ALU, 0, 0, 0, 0);
        check_dbg("postrst_r5", 5, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 7) != 0),
                 core_state_e'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 wr_src_e'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if (n % 25 == 24) check_all_regs("rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4, threads per block; reset value of R14 (%blockDim).
REQ-002 Parameter THREAD_ID, default 0, index of this thread within the block; reset value of R15 (%threadIdx).
REQ-003 Parameter DATA_BITS, default 8, register and operand width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  thread active; 0 freezes all state except reset.
REQ-007 block_id  input  8  current block index, mirrored into R13.
REQ-008 core_state  input  3  core phase: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
REQ-009 decoded_rd_address, decoded_rs_address, decoded_rt_address  input  4 each  destination and source register indices.
REQ-010 decoded_reg_write_enable  input  1  instruction writes rd.
REQ-011 decoded_reg_input_mux  input  2  write source: 00 ALU, 01 LSU, 10 immediate, 11 reserved.
REQ-012 decoded_immediate  input  8  constant write data.
REQ-013 alu_out, lsu_out  input  8 each  ALU result and memory load data.
REQ-014 rs, rt  output  8 each  registered source operands feeding the ALU and LSU.
REQ-015 ro_write_err  output  1  sticky flag: illegal write attempted.
REQ-016 dbg_addr  input  4 / dbg_data  output  8  combinational debug read port.

Function
REQ-017 Storage SHALL be 16 registers of DATA_BITS: R0-R12 general purpose, R13-R15 read-only.
REQ-018 With enable=1 and core_state=REQUEST, rs and rt SHALL load R[decoded_rs_address] and R[decoded_rt_address] on that edge; valid from the next cycle and held until the next REQUEST.
REQ-019 With enable=1, core_state=UPDATE and decoded_reg_write_enable=1, R[decoded_rd_address] SHALL take the mux-selected source on that edge; at most one write per UPDATE cycle.
REQ-020 Writes to R13-R15 SHALL be dropped and SHALL set ro_write_err, which stays 1 until reset.
REQ-021 decoded_reg_input_mux=11 with a write SHALL drop the write and set ro_write_err.
REQ-022 R13 SHALL load block_id on every enabled edge in every core_state, independent of writes.
REQ-023 Reads in REQUEST SHALL return register contents from before the current edge. REQUEST and UPDATE are exclusive, so no write-through path is needed.
REQ-024 With enable=0, rs, rt, registers and ro_write_err SHALL hold; REQUEST and UPDATE events are ignored.
REQ-025 All arithmetic is performed upstream. Sources SHALL be stored unmodified: no extension, no saturation.
REQ-026 dbg_data SHALL equal R[dbg_addr] combinationally, with no side effects.

Reset
REQ-027 Asserting reset SHALL immediately set R0-R13=0, R14=THREADS_PER_BLOCK, R15=THREAD_ID, rs=rt=0 and ro_write_err=0.
REQ-028 Reset asserted during REQUEST or UPDATE SHALL abort that read or write. The first normal edge follows deassertion.

Structure
REQ-029 A shared package SHALL hold the core_state encodings, the write-mux encodings and the read-only indices 13/14/15.
REQ-030 There SHALL be one flat module with no sub-modules. Storage SHALL be a register array, not a RAM macro.

Verification
REQ-031 After reset with THREADS_PER_BLOCK=4 and THREAD_ID=2, reading dbg 14 and dbg 15 -> 4 and 2; dbg 0 -> 0; ro_write_err=0.
REQ-032 UPDATE, rd=3, mux=10, imm=0x5A; then REQUEST rs=3, rt=15 -> next cycle rs=0x5A, rt=THREAD_ID.
REQ-033 UPDATE rd=1 mux=00 alu_out=0x7F, then UPDATE rd=1 mux=01 lsu_out=0x80 -> R1=0x80; the last write wins.
REQ-034 UPDATE rd=14 imm=0x33 -> R14 unchanged and ro_write_err=1; a later legal write leaves the flag at 1.
REQ-035 enable=0 through REQUEST and UPDATE with write_enable=1 -> rs, rt and all registers unchanged; block_id=9 not mirrored. After enable=1 for one cycle, R13=9.
REQ-036 Reset asserted mid-UPDATE with rd=5 imm=0xFF -> R5=0 immediately, rs=rt=0, and no write occurs after deassertion.
